// File: rtl/tulip_prog_pkg.sv
// Shared types for the tulip programming sequencer: FSM states, target indices,
// programming word type and the target-selection helper.
package tulip_prog_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        FINISH = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] TGT_LUT = 2'd0;
    localparam logic [1:0] TGT_FIR = 2'd1;
    localparam logic [1:0] TGT_REV = 2'd2;

    typedef logic [23:0] prog_word_t;

    // Targets are always loaded in ascending index order.
    function automatic logic [1:0] lowest_tgt(input logic [2:0] m);
        if (m[0])      return TGT_LUT;
        else if (m[1]) return TGT_FIR;
        else           return TGT_REV;
    endfunction

endpackage

// File: rtl/tulip_prog_watchdog.sv
// DRAIN-phase watchdog: counts armed cycles and flags expiry on the cycle that
// completes G_TIMEOUT cycles without the target reporting done.
module tulip_prog_watchdog #(
    parameter int G_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic arm,
    output logic expired
);

    localparam int CW = $clog2(G_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (arm && cnt != CW'(G_TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    assign expired = arm && (cnt == CW'(G_TIMEOUT - 1));

endmodule

// File: rtl/tulip_prog_sequencer.sv
// Loads LUT / FIR / reverb tables from one shared programming stream, holding the
// DSP chain in bypass meanwhile. Optional drain timeout: TULIP_PROG_WATCHDOG_EN.
module tulip_prog_sequencer
    import tulip_prog_pkg::*;
#(
    parameter int G_LUT_WORDS    = 1024,
    parameter int G_FIR_WORDS    = 129,
    parameter int G_REV_WORDS    = 64,
    parameter int G_DONE_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [2:0]  target_mask,
    input  prog_word_t  prog_din,
    input  logic        prog_din_valid,
    output logic        prog_din_ready,
    output prog_word_t  lut_prog_din,
    output logic        lut_prog_din_valid,
    input  logic        lut_prog_din_ready,
    input  logic        lut_prog_done,
    output logic [15:0] usr_fir_taps_prog_din,
    output logic        usr_fir_taps_prog_din_valid,
    input  logic        usr_fir_taps_prog_din_ready,
    input  logic        usr_fir_taps_prog_done,
    output logic [15:0] reverb_taps_prog_din,
    output logic        reverb_taps_prog_din_valid,
    input  logic        reverb_taps_prog_din_ready,
    input  logic        reverb_taps_prog_done,
    output logic        busy,
    output logic        seq_done,
    output logic        err,
    output logic [1:0]  err_target,
    output logic        dsp_bypass
);

    localparam int MAX_A = (G_LUT_WORDS > G_FIR_WORDS) ? G_LUT_WORDS : G_FIR_WORDS;
    localparam int MAX_N = (MAX_A > G_REV_WORDS) ? MAX_A : G_REV_WORDS;
    localparam int CW    = $clog2(MAX_N + 1);

    state_t        state;
    logic [1:0]    tgt;
    logic [2:1]    mask;   // bit 0 is never needed after the first target is chosen
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_idx;
    logic [2:0]    hi;
    logic          sel_ready, sel_done, in_load, accept, timeout;

    always_comb begin
        last_idx  = CW'(G_REV_WORDS - 1);
        sel_ready = reverb_taps_prog_din_ready;
        sel_done  = reverb_taps_prog_done;
        hi        = 3'b000;
        case (tgt)
            TGT_LUT: begin
                last_idx  = CW'(G_LUT_WORDS - 1);
                sel_ready = lut_prog_din_ready;
                sel_done  = lut_prog_done;
                hi        = {mask[2:1], 1'b0};
            end
            TGT_FIR: begin
                last_idx  = CW'(G_FIR_WORDS - 1);
                sel_ready = usr_fir_taps_prog_din_ready;
                sel_done  = usr_fir_taps_prog_done;
                hi        = {mask[2], 2'b00};
            end
            default: ;
        endcase
    end

    assign in_load = (state == LOAD);
    assign accept  = in_load && prog_din_valid && sel_ready;

    // Zero-latency pass-through; only the selected target ever sees valid.
    assign prog_din_ready              = in_load && sel_ready;
    assign lut_prog_din                = prog_din;
    assign usr_fir_taps_prog_din       = prog_din[15:0];
    assign reverb_taps_prog_din        = prog_din[15:0];
    assign lut_prog_din_valid          = in_load && (tgt == TGT_LUT) && prog_din_valid;
    assign usr_fir_taps_prog_din_valid = in_load && (tgt == TGT_FIR) && prog_din_valid;
    assign reverb_taps_prog_din_valid  = in_load && (tgt == TGT_REV) && prog_din_valid;

`ifdef TULIP_PROG_WATCHDOG_EN
    logic expired;

    tulip_prog_watchdog #(
        .G_TIMEOUT (G_DONE_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset || !enable),
        .clear   (state != DRAIN),
        .arm     (state == DRAIN),
        .expired (expired)
    );

    assign timeout = expired;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            err        <= 1'b0;
            err_target <= 2'd0;
        end else if (state == IDLE && start) begin
            err        <= 1'b0;
            err_target <= 2'd0;
        end else if (state == DRAIN && !sel_done && timeout) begin
            err        <= 1'b1;
            err_target <= tgt;
        end
    end
`else
    assign timeout    = 1'b0;
    assign err        = 1'b0;
    assign err_target = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state      <= IDLE;
            tgt        <= TGT_LUT;
            mask       <= 2'b00;
            cnt        <= '0;
            busy       <= 1'b0;
            dsp_bypass <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mask       <= target_mask[2:1];
                    cnt        <= '0;
                    busy       <= 1'b1;
                    dsp_bypass <= 1'b1;
                    if (|target_mask) begin
                        tgt   <= lowest_tgt(target_mask);
                        state <= LOAD;
                    end else begin
                        state    <= FINISH;
                        seq_done <= 1'b1;
                    end
                end
                LOAD: if (accept) begin
                    if (cnt == last_idx) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (sel_done) begin
                        if (|hi) begin
                            tgt   <= lowest_tgt(hi);
                            state <= LOAD;
                        end else begin
                            state    <= FINISH;
                            seq_done <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= ERROR;
                    end
                end
                FINISH, ERROR: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    dsp_bypass <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tulip_prog_sequencer.sv
// Randomized self-checking bench for tulip_prog_sequencer; the watchdog scenario
// is built only when TULIP_PROG_WATCHDOG_EN is defined.
module tb_tulip_prog_sequencer;

    localparam int NL = 1024;
    localparam int NF = 129;
    localparam int NR = 64;
    localparam int DT = 4096;

    logic        clk = 1'b0;
    logic        reset, enable, start;
    logic [2:0]  target_mask;
    logic [23:0] prog_din;
    logic        prog_din_valid, prog_din_ready;
    logic [23:0] lut_prog_din;
    logic        lut_prog_din_valid, lut_prog_din_ready, lut_prog_done;
    logic [15:0] usr_fir_taps_prog_din;
    logic        usr_fir_taps_prog_din_valid, usr_fir_taps_prog_din_ready, usr_fir_taps_prog_done;
    logic [15:0] reverb_taps_prog_din;
    logic        reverb_taps_prog_din_valid, reverb_taps_prog_din_ready, reverb_taps_prog_done;
    logic        busy, seq_done, err, dsp_bypass;
    logic [1:0]  err_target;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run observations
    logic [23:0] q_host[$], q_lut[$], q_fir[$], q_rev[$];
    int c_ready_viol, c_valid_viol, c_busy_viol, c_done_cnt, c_finish_cyc;
    bit c_timeout;

    always #5 clk = ~clk;

    tulip_prog_sequencer #(
        .G_LUT_WORDS(NL), .G_FIR_WORDS(NF), .G_REV_WORDS(NR), .G_DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .target_mask(target_mask),
        .prog_din(prog_din), .prog_din_valid(prog_din_valid), .prog_din_ready(prog_din_ready),
        .lut_prog_din(lut_prog_din), .lut_prog_din_valid(lut_prog_din_valid),
        .lut_prog_din_ready(lut_prog_din_ready), .lut_prog_done(lut_prog_done),
        .usr_fir_taps_prog_din(usr_fir_taps_prog_din),
        .usr_fir_taps_prog_din_valid(usr_fir_taps_prog_din_valid),
        .usr_fir_taps_prog_din_ready(usr_fir_taps_prog_din_ready),
        .usr_fir_taps_prog_done(usr_fir_taps_prog_done),
        .reverb_taps_prog_din(reverb_taps_prog_din),
        .reverb_taps_prog_din_valid(reverb_taps_prog_din_valid),
        .reverb_taps_prog_din_ready(reverb_taps_prog_din_ready),
        .reverb_taps_prog_done(reverb_taps_prog_done),
        .busy(busy), .seq_done(seq_done), .err(err), .err_target(err_target),
        .dsp_bypass(dsp_bypass)
    );

    function automatic int nwords(input int t);
        return (t == 0) ? NL : (t == 1) ? NF : NR;
    endfunction

    function automatic logic rdy_of(input int t);
        return (t == 0) ? lut_prog_din_ready : (t == 1) ? usr_fir_taps_prog_din_ready
                                                        : reverb_taps_prog_din_ready;
    endfunction

    function automatic logic [2:0] vmask();
        return {reverb_taps_prog_din_valid, usr_fir_taps_prog_din_valid, lut_prog_din_valid};
    endfunction

    function automatic logic [10:0] all_outs();
        return {vmask(), prog_din_ready, busy, seq_done, err, err_target, dsp_bypass, 1'b0};
    endfunction

    function automatic int rx_size(input int t);
        return (t == 0) ? q_lut.size() : (t == 1) ? q_fir.size() : q_rev.size();
    endfunction

    function automatic logic [23:0] rx_at(input int t, input int i);
        return (t == 0) ? q_lut[i] : (t == 1) ? q_fir[i] : q_rev[i];
    endfunction

    // Words accepted from the host, split in mask order, must arrive per target intact.
    function automatic int payload_errors(input logic [2:0] m);
        int e, base, n;
        logic [23:0] ew;
        e = 0; base = 0;
        for (int t = 0; t < 3; t++) begin
            if (m[t]) begin
                n = nwords(t);
                if (q_host.size() < base + n || rx_size(t) != n) begin
                    e++;
                end else begin
                    for (int i = 0; i < n; i++) begin
                        ew = (t == 0) ? q_host[base+i] : {8'h00, q_host[base+i][15:0]};
                        if (rx_at(t, i) !== ew) e++;
                    end
                end
                base += n;
            end
        end
        if (q_host.size() != base) e++;
        return e;
    endfunction

    task automatic set_done(input int t, input logic v);
        if (t == 0) lut_prog_done = v;
        else if (t == 1) usr_fir_taps_prog_done = v;
        else reverb_taps_prog_done = v;
    endtask

    task automatic idle_inputs();
        start = 0; prog_din_valid = 0; lut_prog_done = 0;
        usr_fir_taps_prog_done = 0; reverb_taps_prog_done = 0;
        lut_prog_din_ready = 1; usr_fir_taps_prog_din_ready = 1; reverb_taps_prog_din_ready = 1;
    endtask

    // Drives one sequence against a word-count model of the sequencer; called just after a posedge.
    task automatic run_seq(input logic [2:0] m, input bit rnd_fir, input bit fixed,
                           input logic [23:0] word, input int restart_at);
        int tl[$];
        int p, w, nt, cur, n, done_at;
        bit fin, ended;
        q_host.delete(); q_lut.delete(); q_fir.delete(); q_rev.delete();
        c_ready_viol = 0; c_valid_viol = 0; c_busy_viol = 0; c_done_cnt = 0;
        c_finish_cyc = -1; ended = 0; fin = 0;
        for (int t = 0; t < 3; t++) if (m[t]) tl.push_back(t);
        nt = tl.size(); p = 0; w = 0; done_at = -1;
        for (int c = 0; c < 20000; c++) begin
            start          = (c == 0) || (c == restart_at);
            target_mask    = (c == 0) ? m : ~m;
            prog_din       = fixed ? word : 24'($urandom);
            prog_din_valid = ($urandom_range(0, 9) < 8);
            lut_prog_din_ready          = 1;
            reverb_taps_prog_din_ready  = 1;
            usr_fir_taps_prog_din_ready = rnd_fir ? 1'($urandom_range(0, 1)) : 1'b1;
            lut_prog_done = 0; usr_fir_taps_prog_done = 0; reverb_taps_prog_done = 0;
            if (c > 0 && p < nt) begin
                if (w < nwords(tl[p])) set_done(tl[p], $urandom_range(0, 3) == 0);
                else if (c == done_at) set_done(tl[p], 1'b1);
            end
            @(negedge clk);
            if (c == 0) begin
                if (busy !== 1'b0 || prog_din_ready !== 1'b0 || vmask() !== 3'b000) c_busy_viol++;
            end else if (p < nt) begin
                cur = tl[p]; n = nwords(cur);
                if (busy !== 1'b1 || dsp_bypass !== 1'b1 || seq_done !== 1'b0) c_busy_viol++;
                if (w < n) begin
                    if (prog_din_ready !== rdy_of(cur)) c_ready_viol++;
                    if (vmask() !== (3'(prog_din_valid) << cur)) c_valid_viol++;
                end else begin
                    if (prog_din_ready !== 1'b0) c_ready_viol++;
                    if (vmask() !== 3'b000) c_valid_viol++;
                end
            end else if (!fin) begin
                if (seq_done !== 1'b1 || busy !== 1'b1 || prog_din_ready !== 1'b0) c_busy_viol++;
                if (vmask() !== 3'b000) c_valid_viol++;
                fin = 1; c_finish_cyc = c;
            end else begin
                if (busy !== 1'b0 || dsp_bypass !== 1'b0 || seq_done !== 1'b0) c_busy_viol++;
                if (vmask() !== 3'b000) c_valid_viol++;
            end
            if (seq_done === 1'b1) c_done_cnt++;
            if (lut_prog_din_valid && lut_prog_din_ready) q_lut.push_back(lut_prog_din);
            if (usr_fir_taps_prog_din_valid && usr_fir_taps_prog_din_ready)
                q_fir.push_back({8'h00, usr_fir_taps_prog_din});
            if (reverb_taps_prog_din_valid && reverb_taps_prog_din_ready)
                q_rev.push_back({8'h00, reverb_taps_prog_din});
            if (c > 0 && p < nt) begin
                cur = tl[p]; n = nwords(cur);
                if (w < n) begin
                    if (prog_din_valid && rdy_of(cur)) begin
                        q_host.push_back(prog_din);
                        w++;
                        if (w == n) done_at = c + 2;
                    end
                end else if (c == done_at) begin
                    p++; w = 0;
                end
            end
            @(posedge clk); #1;
            if (fin && c > c_finish_cyc) begin ended = 1; break; end
        end
        c_timeout = !ended;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; target_mask = 0; prog_din = 0; idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_outs() !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 0", all_outs());
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_all_targets();
        run_seq(3'b111, 0, 0, 24'h0, -1);
        n_checks++;
        if (c_timeout !== 1'b0) begin n_fail++; $display("FAIL all_timeout: sequence never finished"); end
        n_checks++;
        if (q_lut.size() != NL || q_fir.size() != NF || q_rev.size() != NR) begin
            n_fail++; $display("FAIL all_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                               q_lut.size(), q_fir.size(), q_rev.size(), NL, NF, NR);
        end
        n_checks++;
        if (payload_errors(3'b111) != 0) begin
            n_fail++; $display("FAIL all_payload: %0d word errors required 0", payload_errors(3'b111));
        end
        n_checks++;
        if (c_done_cnt != 1) begin n_fail++; $display("FAIL all_seq_done: got %0d pulses required 1", c_done_cnt); end
        n_checks++;
        if (c_busy_viol != 0 || c_valid_viol != 0 || c_ready_viol != 0) begin
            n_fail++; $display("FAIL all_handshake: busy %0d valid %0d ready %0d violations required 0",
                               c_busy_viol, c_valid_viol, c_ready_viol);
        end
    endtask

    task automatic test_reverb_only();
        int bad;
        run_seq(3'b100, 0, 1, 24'hABCDEF, 20);
        bad = 0;
        foreach (q_rev[i]) if (q_rev[i] !== 24'h00CDEF) bad++;
        n_checks++;
        if (q_rev.size() != NR || bad != 0) begin
            n_fail++; $display("FAIL rev_data: got %0d words %0d wrong required %0d of CDEF", q_rev.size(), bad, NR);
        end
        n_checks++;
        if (q_lut.size() != 0 || q_fir.size() != 0 || c_valid_viol != 0) begin
            n_fail++; $display("FAIL rev_other_valid: lut %0d fir %0d viol %0d required 0",
                               q_lut.size(), q_fir.size(), c_valid_viol);
        end
        n_checks++;
        if (c_done_cnt != 1 || c_busy_viol != 0 || c_timeout) begin
            n_fail++; $display("FAIL rev_restart_ignored: done %0d busy viol %0d required 1/0", c_done_cnt, c_busy_viol);
        end
    endtask

    task automatic test_fir_random_ready();
        run_seq(3'b010, 1, 0, 24'h0, -1);
        n_checks++;
        if (payload_errors(3'b010) != 0 || q_fir.size() != NF) begin
            n_fail++; $display("FAIL fir_payload: got %0d words %0d errors required %0d/0",
                               q_fir.size(), payload_errors(3'b010), NF);
        end
        n_checks++;
        if (c_ready_viol != 0) begin n_fail++; $display("FAIL fir_ready: got %0d violations required 0", c_ready_viol); end
        n_checks++;
        if (c_valid_viol != 0 || c_busy_viol != 0 || c_done_cnt != 1) begin
            n_fail++; $display("FAIL fir_status: valid %0d busy %0d done %0d required 0/0/1",
                               c_valid_viol, c_busy_viol, c_done_cnt);
        end
    endtask

    task automatic test_zero_mask();
        run_seq(3'b000, 0, 0, 24'h0, 1);
        n_checks++;
        if (c_finish_cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 1", c_finish_cyc); end
        n_checks++;
        if (c_done_cnt != 1 || c_busy_viol != 0) begin
            n_fail++; $display("FAIL zero_status: done %0d busy viol %0d required 1/0", c_done_cnt, c_busy_viol);
        end
        n_checks++;
        if (c_valid_viol != 0 || q_lut.size() + q_fir.size() + q_rev.size() != 0) begin
            n_fail++; $display("FAIL zero_valid: viol %0d words %0d required 0", c_valid_viol,
                               q_lut.size() + q_fir.size() + q_rev.size());
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        bit hit;
        cnt = 0; hit = 0;
        target_mask = 3'b001; prog_din_valid = 1;
        for (int c = 0; c < 2000; c++) begin
            start = (c == 0); prog_din = 24'($urandom);
            @(negedge clk);
            if (lut_prog_din_valid && lut_prog_din_ready) cnt++;
            @(posedge clk); #1;
            if (cnt == 500) begin hit = 1; break; end
        end
        start = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        n_checks++;
        if (!hit || all_outs() !== 11'd0) begin
            n_fail++; $display("FAIL reset_mid: reached %0d outputs %b required 0", hit, all_outs());
        end
        @(posedge clk); #1;
        idle_inputs();
        run_seq(3'b001, 0, 0, 24'h0, -1);
        n_checks++;
        if (q_lut.size() != NL || payload_errors(3'b001) != 0 || c_done_cnt != 1 || c_timeout) begin
            n_fail++; $display("FAIL reset_restart: got %0d words %0d errors required %0d/0",
                               q_lut.size(), payload_errors(3'b001), NL);
        end
    endtask

`ifdef TULIP_PROG_WATCHDOG_EN
    task automatic test_watchdog();
        int cnt, k, fir_seen, early_err;
        bit ok_at, ok_after;
        cnt = 0; k = -1; fir_seen = 0; early_err = 0; ok_at = 0; ok_after = 0;
        target_mask = 3'b011; prog_din_valid = 1;
        for (int c = 0; c < 7000; c++) begin
            start = (c == 0); prog_din = 24'($urandom);
            @(negedge clk);
            if (usr_fir_taps_prog_din_valid) fir_seen++;
            if (lut_prog_din_valid && lut_prog_din_ready) begin
                cnt++;
                if (cnt == NL) k = c;
            end
            if (k >= 0 && c < k + DT + 1 && err !== 1'b0) early_err++;
            if (k >= 0 && c == k + DT + 1) ok_at = (err === 1'b1) && (err_target === 2'd0);
            if (k >= 0 && c == k + DT + 2) begin
                ok_after = (busy === 1'b0) && (err === 1'b1) && (seq_done === 1'b0);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        n_checks++;
        if (!ok_at || early_err != 0) begin
            n_fail++; $display("FAIL wd_err: at-timeout ok %0d early %0d required 1/0", ok_at, early_err);
        end
        n_checks++;
        if (!ok_after) begin n_fail++; $display("FAIL wd_idle: busy %b err %b required 0/1", busy, err); end
        n_checks++;
        if (fir_seen != 0) begin n_fail++; $display("FAIL wd_fir_skipped: got %0d fir valids required 0", fir_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_all_targets();
        test_reverb_only();
        test_fir_random_ready();
        test_zero_mask();
        test_reset_mid();
`ifdef TULIP_PROG_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
